// File: rtl/mt_state_recovery.sv
// Rebuilds MT19937 generator state from its tempered output stream, then predicts the following outputs.
// Optional MT_RECOVER_CHECK_EN: in READY, accepted words are compared against predictions (sticky mismatch).
`timescale 1ns/1ps
module mt_state_recovery #(
    parameter int             W = 32,
    parameter int             N = 624,
    parameter int             M = 397,
    parameter logic [W-1:0]   A = 32'h9908B0DF,
    parameter int             R = 31,
    parameter int             U = 11,
    parameter int             S = 7,
    parameter logic [W-1:0]   B = 32'h9D2C5680,
    parameter int             T = 15,
    parameter logic [W-1:0]   C = 32'hEFC60000,
    parameter int             L = 18
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_word,
    output logic         in_ready,
    output logic         recovered,
    input  logic         pred_req,
    output logic         pred_valid,
    output logic [W-1:0] pred_word,
    output logic         mismatch,
    output logic [1:0]   dbg_state
);
    // Handshake: a word transfers on a rising edge where in_valid & in_ready; nothing downstream can stall.

    localparam int            IW    = $clog2(N);
    localparam logic [IW-1:0] LAST  = IW'(N - 1);
    localparam logic [IW-1:0] M_OFS = IW'(M);
    localparam logic [IW-1:0] M_LIM = IW'(N - M);

    typedef enum logic [1:0] {FILL = 2'd0, DRAIN = 2'd1, READY = 2'd2} state_t;

    function automatic logic [W-1:0] inv_rshift(input logic [W-1:0] y, input int sh);
        logic [W-1:0] x;
        x = y;
        for (int k = 1; k < (W + sh - 1) / sh; k++) x = y ^ (x >> sh);
        return x;
    endfunction

    function automatic logic [W-1:0] inv_lshift(input logic [W-1:0] y, input int sh,
                                                input logic [W-1:0] mask);
        logic [W-1:0] x;
        x = y;
        for (int k = 1; k < (W + sh - 1) / sh; k++) x = y ^ ((x << sh) & mask);
        return x;
    endfunction

    function automatic logic [W-1:0] temper(input logic [W-1:0] x);
        logic [W-1:0] y;
        y = x ^ (x >> U);
        y = y ^ ((y << S) & B);
        y = y ^ ((y << T) & C);
        y = y ^ (y >> L);
        return y;
    endfunction

    state_t        state_q, state_d;
    logic [IW-1:0] acc_cnt_q, wr_idx_q, rd_idx_q;
    logic [3:0]    vld_q;
    logic [W-1:0]  stg_q [4];
    logic [W-1:0]  buf_q [N];
    logic          recovered_q, pred_valid_q;
    logic [W-1:0]  pred_word_q;

    logic          accept, fill_accept, chk_accept, wr_en, last_write, step;
    logic [IW-1:0] idx1, idxm;
    logic [W-1:0]  y_tw, x_tw, pred_temper;

    assign accept      = in_valid & in_ready;
    assign fill_accept = accept && (state_q == FILL);
    assign wr_en       = vld_q[3] && !flush;
    assign last_write  = wr_en && (wr_idx_q == LAST);

    // Neighbour indices modulo N by compare-and-subtract
    assign idx1 = (rd_idx_q == LAST) ? '0 : rd_idx_q + 1'b1;
    assign idxm = (rd_idx_q >= M_LIM) ? rd_idx_q - M_LIM : rd_idx_q + M_OFS;

    assign y_tw        = {buf_q[rd_idx_q][W-1:R], buf_q[idx1][R-1:0]};
    assign x_tw        = buf_q[idxm] ^ (y_tw >> 1) ^ (y_tw[0] ? A : '0);
    assign pred_temper = temper(x_tw);

`ifdef MT_RECOVER_CHECK_EN
    logic mismatch_q;
    assign in_ready   = (state_q == FILL) || (state_q == READY);
    assign chk_accept = accept && (state_q == READY);
    assign mismatch   = mismatch_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                                        mismatch_q <= 1'b0;
        else if (flush)                                    mismatch_q <= 1'b0;
        else if (chk_accept && (in_word != pred_temper))   mismatch_q <= 1'b1;
    end
`else
    assign in_ready   = (state_q == FILL);
    assign chk_accept = 1'b0;
    assign mismatch   = 1'b0;
`endif

    // A checked word and a same-cycle pred_req share one prediction
    assign step = (state_q == READY) && (pred_req || chk_accept) && !flush;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL:    if (fill_accept && (acc_cnt_q == LAST)) state_d = DRAIN;
                DRAIN:   if (last_write) state_d = READY;
                READY:   state_d = READY;
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= FILL;
            acc_cnt_q    <= '0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            vld_q        <= '0;
            recovered_q  <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_word_q  <= '0;
        end else if (flush) begin
            state_q      <= FILL;
            acc_cnt_q    <= '0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            vld_q        <= '0;
            recovered_q  <= 1'b0;
            pred_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vld_q        <= {vld_q[2:0], fill_accept};
            pred_valid_q <= (state_q == READY) && pred_req;
            if (fill_accept) acc_cnt_q <= acc_cnt_q + 1'b1;
            if (wr_en)       wr_idx_q  <= (wr_idx_q == LAST) ? '0 : wr_idx_q + 1'b1;
            if (last_write && (state_q == DRAIN)) begin
                recovered_q <= 1'b1;
                rd_idx_q    <= '0;
            end
            if (step) begin
                pred_word_q <= pred_temper;
                rd_idx_q    <= idx1;
            end
        end
    end

    // Untemper stages undo the tempering steps in reverse order; data needs no reset
    always_ff @(posedge clk) begin
        stg_q[0] <= inv_rshift(in_word, L);
        stg_q[1] <= inv_lshift(stg_q[0], T, C);
        stg_q[2] <= inv_lshift(stg_q[1], S, B);
        stg_q[3] <= inv_rshift(stg_q[2], U);
        if (wr_en)     buf_q[wr_idx_q] <= stg_q[3];
        else if (step) buf_q[rd_idx_q] <= x_tw;
    end

    assign recovered  = recovered_q;
    assign pred_valid = pred_valid_q;
    assign pred_word  = pred_word_q;
    assign dbg_state  = state_q;

endmodule
